// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: request and ID/EX issue channels for alu_issue_stage; ILLEGAL_INSTR_FLAG_EN adds the illegal flag
interface alu_issue_req_if #(parameter int DATA_WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [31:0] instr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  modport master (output in_valid, instr, rs1_data, rs2_data, input in_ready);
  modport slave (input in_valid, instr, rs1_data, rs2_data, output in_ready);
endinterface

interface alu_issue_ex_if #(parameter int DATA_WIDTH = 32);
  logic out_valid;
  logic out_ready;
  logic [2:0] ALUctrl;
  logic [DATA_WIDTH-1:0] ALUop1;
  logic [DATA_WIDTH-1:0] ALUop2;
  logic [DATA_WIDTH-1:0] store_data;
  logic [4:0] rd_addr;
  logic reg_write;
  logic mem_read;
  logic mem_write;
  logic branch;
  logic branch_ne;
`ifdef ILLEGAL_INSTR_FLAG_EN
  logic illegal;
  modport master (output out_valid, ALUctrl, ALUop1, ALUop2, store_data, rd_addr, reg_write, mem_read,
                  mem_write, branch, branch_ne, illegal, input out_ready);
  modport slave (input out_valid, ALUctrl, ALUop1, ALUop2, store_data, rd_addr, reg_write, mem_read,
                 mem_write, branch, branch_ne, illegal, output out_ready);
`else
  modport master (output out_valid, ALUctrl, ALUop1, ALUop2, store_data, rd_addr, reg_write, mem_read,
                  mem_write, branch, branch_ne, input out_ready);
  modport slave (input out_valid, ALUctrl, ALUop1, ALUop2, store_data, rd_addr, reg_write, mem_read,
                 mem_write, branch, branch_ne, output out_ready);
`endif
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode into a registered ID/EX slot for the ALU; ILLEGAL_INSTR_FLAG_EN adds an illegal output
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  alu_issue_req_if.slave req,
  alu_issue_ex_if.master ex
);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  typedef struct packed {
    logic [2:0]            ctrl;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] sd;
    logic [4:0]            rd;
    logic                  rw;
    logic                  mr;
    logic                  mw;
    logic                  br;
    logic                  bne;
  } ent_t;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, shamt;
  logic r_ok, i_ok, legal, cap, vld;
  ent_t dec, ent;
  assign opc = req.instr[6:0];
  assign f3 = req.instr[14:12];
  assign f7 = req.instr[31:25];
  assign imm_i = {{(DATA_WIDTH-12){req.instr[31]}}, req.instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){req.instr[31]}}, f7, req.instr[11:7]};
  assign shamt = {{(DATA_WIDTH-5){1'b0}}, req.instr[24:20]};
  assign r_ok = (f7 == 7'b0 && f3[2:1] != 2'b01) || (f7 == 7'b0100000 && f3 == 3'b000);
  assign i_ok = f3[1:0] == 2'b01 ? f7 == 7'b0 : f3[2:1] != 2'b01;
  assign legal = opc == OP_R ? r_ok :
                 opc == OP_I ? i_ok :
                 opc == OP_L || opc == OP_S ? f3 == 3'b010 :
                 opc == OP_B ? f3[2:1] == 2'b00 : 1'b0;
  assign req.in_ready = !vld || ex.out_ready;
  assign cap = req.in_valid && req.in_ready && !flush;
  // Decode the incoming instruction; anything unsupported collapses to an all-zero NOP entry
  always_comb begin
    dec = '0;
    dec.op1 = req.rs1_data;
    dec.op2 = opc == OP_R || opc == OP_B ? req.rs2_data :
              opc == OP_S ? imm_s :
              opc == OP_I && f3[1:0] == 2'b01 ? shamt : imm_i;
    dec.ctrl = opc == OP_B ? 3'b001 :
               opc != OP_R && opc != OP_I ? 3'b000 :
               f3 == 3'b000 ? {2'b00, opc == OP_R && f7[5]} :
               f3 == 3'b001 ? 3'b010 : f3;
    dec.sd = opc == OP_S ? req.rs2_data : '0;
    dec.rd = opc == OP_S || opc == OP_B ? 5'd0 : req.instr[11:7];
    dec.rw = (opc == OP_R || opc == OP_I || opc == OP_L) && dec.rd != 5'd0;
    dec.mr = opc == OP_L;
    dec.mw = opc == OP_S;
    dec.br = opc == OP_B;
    dec.bne = opc == OP_B && f3[0];
    if (!legal) dec = '0;
  end
  // ID/EX slot: flush drops both the held entry and any same-cycle capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      ent <= '0;
    end else begin
      vld <= !flush && (cap || (vld && !ex.out_ready));
      if (cap) ent <= dec;
    end
  end
`ifdef ILLEGAL_INSTR_FLAG_EN
  logic ill;
  // Illegal flag travels with the entry it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill <= 1'b0;
    else if (cap) ill <= !legal;
  end
  assign ex.illegal = ill;
`endif
  assign ex.out_valid = vld;
  assign ex.ALUctrl = ent.ctrl;
  assign ex.ALUop1 = ent.op1;
  assign ex.ALUop2 = ent.op2;
  assign ex.store_data = ent.sd;
  assign ex.rd_addr = ent.rd;
  assign ex.reg_write = ent.rw;
  assign ex.mem_read = ent.mr;
  assign ex.mem_write = ent.mw;
  assign ex.branch = ent.br;
  assign ex.branch_ne = ent.bne;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors against a mnemonic-level reference decoder and slot model
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;
  alu_issue_req_if #(.DATA_WIDTH(32)) req ();
  alu_issue_ex_if #(.DATA_WIDTH(32)) ex ();
  alu_issue_stage #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .ex(ex));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] op1, op2, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, bne, ill;
  } exp_t;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", n, got, want, $time);
    end
  endtask
  function automatic exp_t mk(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                              input logic w, input logic mr, input logic mw, input logic br, input logic bne,
                              input logic [31:0] sd);
    exp_t e;
    e.ctrl = c; e.op1 = a; e.op2 = b; e.rd = rd; e.rw = w && rd != 0;
    e.mr = mr; e.mw = mw; e.br = br; e.bne = bne; e.sd = sd; e.ill = 0;
    return e;
  endfunction
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] imm, simm, sh;
    logic [4:0] rd;
    imm = {{20{i[31]}}, i[31:20]};
    simm = {{20{i[31]}}, i[31:25], i[11:7]};
    sh = {27'd0, i[24:20]};
    rd = i[11:7];
    e = '{ctrl: 0, op1: 0, op2: 0, sd: 0, rd: 0, rw: 0, mr: 0, mw: 0, br: 0, bne: 0, ill: 1};
    casez ({i[31:25], i[14:12], i[6:0]})
      17'b0000000_000_0110011: e = mk(3'b000, a, b, rd, 1, 0, 0, 0, 0, 0);
      17'b0100000_000_0110011: e = mk(3'b001, a, b, rd, 1, 0, 0, 0, 0, 0);
      17'b0000000_111_0110011: e = mk(3'b111, a, b, rd, 1, 0, 0, 0, 0, 0);
      17'b0000000_110_0110011: e = mk(3'b110, a, b, rd, 1, 0, 0, 0, 0, 0);
      17'b0000000_100_0110011: e = mk(3'b100, a, b, rd, 1, 0, 0, 0, 0, 0);
      17'b0000000_001_0110011: e = mk(3'b010, a, b, rd, 1, 0, 0, 0, 0, 0);
      17'b0000000_101_0110011: e = mk(3'b101, a, b, rd, 1, 0, 0, 0, 0, 0);
      17'b???????_000_0010011: e = mk(3'b000, a, imm, rd, 1, 0, 0, 0, 0, 0);
      17'b???????_111_0010011: e = mk(3'b111, a, imm, rd, 1, 0, 0, 0, 0, 0);
      17'b???????_110_0010011: e = mk(3'b110, a, imm, rd, 1, 0, 0, 0, 0, 0);
      17'b???????_100_0010011: e = mk(3'b100, a, imm, rd, 1, 0, 0, 0, 0, 0);
      17'b0000000_001_0010011: e = mk(3'b010, a, sh, rd, 1, 0, 0, 0, 0, 0);
      17'b0000000_101_0010011: e = mk(3'b101, a, sh, rd, 1, 0, 0, 0, 0, 0);
      17'b???????_010_0000011: e = mk(3'b000, a, imm, rd, 1, 1, 0, 0, 0, 0);
      17'b???????_010_0100011: e = mk(3'b000, a, simm, 0, 0, 0, 1, 0, 0, b);
      17'b???????_000_1100011: e = mk(3'b001, a, b, 0, 0, 0, 0, 1, 0, 0);
      17'b???????_001_1100011: e = mk(3'b001, a, b, 0, 0, 0, 0, 1, 1, 0);
      default: ;
    endcase
    return e;
  endfunction
  logic m_v = 1'b0;
  exp_t m_e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_v = 1'b0;
    else if (flush) m_v = 1'b0;
    else if (req.in_valid && (!m_v || ex.out_ready)) begin
      m_v = 1'b1;
      m_e = ref_dec(req.instr, req.rs1_data, req.rs2_data);
    end else if (ex.out_ready) m_v = 1'b0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", req.in_ready, !m_v || ex.out_ready);
      chk("out_valid", ex.out_valid, m_v);
      if (m_v) begin
        chk("ALUctrl", ex.ALUctrl, m_e.ctrl);
        chk("ALUop1", ex.ALUop1, m_e.op1);
        chk("ALUop2", ex.ALUop2, m_e.op2);
        chk("store_data", ex.store_data, m_e.sd);
        chk("rd_addr", ex.rd_addr, m_e.rd);
        chk("reg_write", ex.reg_write, m_e.rw);
        chk("mem_read", ex.mem_read, m_e.mr);
        chk("mem_write", ex.mem_write, m_e.mw);
        chk("branch", ex.branch, m_e.br);
        chk("branch_ne", ex.branch_ne, m_e.bne);
`ifdef ILLEGAL_INSTR_FLAG_EN
        chk("illegal", ex.illegal, m_e.ill);
`endif
      end
    end
  end
  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    req.instr = i; req.rs1_data = a; req.rs2_data = b; req.in_valid = 1'b1;
    @(posedge clk); #1;
    req.in_valid = 1'b0;
  endtask
  logic [31:0] vec [17] = '{32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3, 32'h002091B3, 32'h0020D1B3,
                            32'h0040A303, 32'h00208463, 32'h00209463, 32'h00309213, 32'h01F0D213,
                            32'h4030D213, 32'h0020A1B3, 32'h0000007F, 32'h0FF0C213, 32'h80008293,
                            32'h02208033, 32'hFE20AE23};
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    logic acc;
    req.in_valid = 0; req.instr = 0; req.rs1_data = 0; req.rs2_data = 0; ex.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ex.out_valid, 0);
    chk("rst_ctrl", ex.ALUctrl, 0);
    chk("rst_op1", ex.ALUop1, 0);
    rst_n = 1;
    #1 chk("rst_in_ready", req.in_ready, 1);
    @(posedge clk); #1;
    issue(32'h402081B3, 7, 2);
    chk("sub_valid", ex.out_valid, 1);
    chk("sub_ctrl", ex.ALUctrl, 3'b001);
    chk("sub_op1", ex.ALUop1, 7);
    chk("sub_op2", ex.ALUop2, 2);
    chk("sub_rd", ex.rd_addr, 3);
    chk("sub_rw", ex.reg_write, 1);
    issue(32'hFFF08293, 10, 0);
    chk("addi_ctrl", ex.ALUctrl, 0);
    chk("addi_op2", ex.ALUop2, 32'hFFFFFFFF);
    chk("addi_rw", ex.reg_write, 1);
    issue(32'h0020A423, 5, 32'h1234);
    chk("sw_op2", ex.ALUop2, 8);
    chk("sw_mw", ex.mem_write, 1);
    chk("sw_sd", ex.store_data, 32'h1234);
    chk("sw_rw", ex.reg_write, 0);
    issue(32'h0020F1B3, 32'hF0, 32'h3C);
    ex.out_ready = 0;
    req.instr = 32'h00208033; req.rs1_data = 32'h11; req.rs2_data = 32'h22; req.in_valid = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_in_ready", req.in_ready, 0);
      chk("hold_op1", ex.ALUop1, 32'hF0);
      chk("hold_ctrl", ex.ALUctrl, 3'b111);
    end
    ex.out_ready = 1;
    @(posedge clk); #1;
    req.in_valid = 0;
    chk("resume_op1", ex.ALUop1, 32'h11);
    chk("resume_rw_x0", ex.reg_write, 0);
    req.instr = 32'h0040A303; req.in_valid = 1; flush = 1;
    @(posedge clk); #1;
    flush = 0; req.in_valid = 0;
    chk("flush_valid", ex.out_valid, 0);
    issue(32'h4020D1B3, 9, 9);
    chk("sra_valid", ex.out_valid, 1);
    chk("sra_ctrl", ex.ALUctrl, 0);
    chk("sra_op1", ex.ALUop1, 0);
    chk("sra_op2", ex.ALUop2, 0);
    chk("sra_rw", ex.reg_write, 0);
`ifdef ILLEGAL_INSTR_FLAG_EN
    chk("sra_illegal", ex.illegal, 1);
`endif
    issue(32'h00209463, 4, 4);
    chk("bne_br", ex.branch, 1);
    chk("bne_ne", ex.branch_ne, 1);
    chk("bne_ctrl", ex.ALUctrl, 3'b001);
    issue(32'h0040A303, 32'h100, 0);
    #3 rst_n = 0;
    #1;
    chk("arst_valid", ex.out_valid, 0);
    chk("arst_mr", ex.mem_read, 0);
    @(posedge clk); #1;
    rst_n = 1;
    #1 chk("arst_in_ready", req.in_ready, 1);
    for (int k = 0; k < 17; k++) begin
      req.instr = vec[k]; req.rs1_data = 32'h1000_0000 + k * 7; req.rs2_data = 32'hFFFF_0000 ^ k;
      req.in_valid = 1;
      ex.out_ready = (k % 3) != 1;
      acc = 0;
      for (int t = 0; t < 8 && !acc; t++) begin
        acc = req.in_ready;
        @(posedge clk); #1;
        ex.out_ready = 1;
      end
      chk("accept", acc, 1);
    end
    req.in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
